// File: rtl/neuron_lut_arb_pkg.sv
// neuron_lut_arb_pkg
// Shared constants for the neuron LUT arbiter slice:
//   DEF_IN_W / DEF_OUT_W : default LUT input / output widths
//   STAT_W               : width of the optional statistics counters
//   clog2()              : elaboration-time ceiling log2, used for index widths
//                          and for checking that the requester tag is wide enough
package neuron_lut_arb_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 2;
    localparam int STAT_W    = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_lut_arb_if.sv
// neuron_lut_arb_if
// Bundles the requester handshakes, the shared LUT connection and the tagged
// response channel of the neuron LUT arbiter.
//   req_valid / req_data / req_ready : NUM_REQ requester handshakes
//   lut_in / lut_out                 : registered word to the shared LUT and its result
//   rsp_valid / rsp_data / rsp_id    : response channel, rsp_ready is the backpressure
// Modports: slave = arbiter side, master = surrounding logic side.
interface neuron_lut_arb_if
    import neuron_lut_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [IN_W-1:0]         lut_in;
    logic [OUT_W-1:0]        lut_out;
    logic                    rsp_valid;
    logic [OUT_W-1:0]        rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_ready;

    modport slave (
        input  req_valid, req_data, lut_out, rsp_ready,
        output req_ready, lut_in, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_data, lut_out, rsp_ready,
        input  req_ready, lut_in, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/neuron_lut_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin search: starting at index ptr and wrapping
// modulo NUM_REQ, the first set bit of req is granted.
//   req       : request vector
//   ptr       : search start index (must be < NUM_REQ)
//   grant_oh  : one-hot grant, zero when nothing requests
//   grant_idx : index of the granted requester (0 when nothing requests)
//   any       : at least one request present
module rr_arbiter
    import neuron_lut_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int j;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any         = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/neuron_lut_arbiter.sv
// neuron_lut_arbiter
// Shares one combinational neuron truth-table LUT between NUM_REQ requesters.
// Round-robin arbitration feeds a two-stage registered pipeline:
//   S1 holds the granted word (drives lut_in) and its requester id,
//   S2 captures the LUT result and presents it on the tagged response channel.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : neuron_lut_arb_if.slave (requester handshakes, LUT link, response)
//   stat_grants / stat_stalls : saturating handshake / stall counters, present
//                               only when NEURON_LUT_ARB_STATS_EN is defined
module neuron_lut_arbiter
    import neuron_lut_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int ID_W    = 2
) (
    input  logic clk,
    input  logic rst,
    neuron_lut_arb_if.slave bus
`ifdef NEURON_LUT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0] stat_stalls
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

    if (ID_W < clog2(NUM_REQ)) begin : g_bad_id_w
        $error("neuron_lut_arbiter: ID_W too narrow for NUM_REQ");
    end

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]    s1_data_q, s1_data_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [PTR_W-1:0]   grant_idx;
    logic               any_req;
    logic               s1_adv;
    logic               s2_adv;
    logic               hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    always_comb begin
        s2_adv = !rsp_valid_q || bus.rsp_ready;
        s1_adv = !s1_valid_q || s2_adv;
        // Gating with rst keeps req_ready low during the reset cycle so no
        // requester believes a word was taken that the reset then discards.
        hs     = s1_adv && any_req && !rst;

        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        if (hs) begin
            ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        // Only a handshake reloads S1 data, so lut_in stays stable otherwise.
        if (s1_adv) begin
            s1_valid_d = hs;
        end
        if (hs) begin
            s1_data_d = bus.req_data[int'(grant_idx)*IN_W +: IN_W];
            s1_id_d   = ID_W'(grant_idx);
        end

        // Data and id hold when a bubble moves into S2.
        if (s2_adv) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_d = bus.lut_out;
                rsp_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.req_ready = hs ? grant_oh : '0;
    assign bus.lut_in    = s1_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef NEURON_LUT_ARB_STATS_EN
    logic [STAT_W-1:0] stat_grants_q;
    logic [STAT_W-1:0] stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (hs && (stat_grants_q != '1)) begin
                stat_grants_q <= stat_grants_q + 1'b1;
            end
            if (rsp_valid_q && !bus.rsp_ready && (stat_stalls_q != '1)) begin
                stat_stalls_q <= stat_stalls_q + 1'b1;
            end
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_neuron_lut_arbiter.sv
// tb_neuron_lut_arbiter
// Directed bench for neuron_lut_arbiter with a small truth-table LUT model.
// Covers reset, single request latency, full contention, backpressure,
// fairness with gaps, reset mid-stream and (with NEURON_LUT_ARB_STATS_EN)
// the statistics counters.
module tb_neuron_lut_arbiter;
    import neuron_lut_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

`ifdef NEURON_LUT_ARB_STATS_EN
    logic [STAT_W-1:0] stat_grants;
    logic [STAT_W-1:0] stat_stalls;
`endif

    neuron_lut_arb_if #(.NUM_REQ(4), .IN_W(8), .OUT_W(2), .ID_W(2)) bus ();

    neuron_lut_arbiter #(.NUM_REQ(4), .IN_W(8), .OUT_W(2), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NEURON_LUT_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stalls (stat_stalls)
`endif
    );

    function automatic logic [1:0] lut_model(input logic [7:0] w);
        case (w)
            8'h00, 8'h10, 8'h04, 8'h01: return 2'b10;
            default:                    return 2'b11;
        endcase
    endfunction

    assign bus.lut_out = lut_model(bus.lut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    logic [7:0] bp_w [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        logic hs;

        n_cmp = 0;
        n_err = 0;
        bp_w[0] = 8'h01; bp_w[1] = 8'h02; bp_w[2] = 8'h04; bp_w[3] = 8'h10;
        bp_w[4] = 8'h20; bp_w[5] = 8'h00; bp_w[6] = 8'h05; bp_w[7] = 8'h08;

        // Reset state; req_ready stays low while rst is high even with requests.
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_lut_in", 32'(bus.lut_in), 32'h0);

        // Single request from requester 2: response two cycles later.
        bus.req_data  = {8'h00, 8'h10, 8'h00, 8'h00};
        bus.req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_t1_valid", 32'(bus.rsp_valid), 32'h0);
        chk("single_lut_in", 32'(bus.lut_in), 32'h10);
        tick();
        chk("single_t2_valid", 32'(bus.rsp_valid), 32'h1);
        chk("single_t2_data", 32'(bus.rsp_data), 32'h2);
        chk("single_t2_id", 32'(bus.rsp_id), 32'h2);
        tick();
        chk("single_t3_valid", 32'(bus.rsp_valid), 32'h0);

        // Full contention from pointer 0.
        do_reset();
        bus.req_data = {8'hFF, 8'h04, 8'h40, 8'h00};
        for (int i = 0; i < 11; i++) begin
            bus.req_valid = (i < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (i < 8) chk("cont_ready", 32'(bus.req_ready), 32'(1 << (i % 4)));
            if (i >= 2 && i < 10) begin
                chk("cont_valid", 32'(bus.rsp_valid), 32'h1);
                chk("cont_id", 32'(bus.rsp_id), 32'((i - 2) % 4));
                chk("cont_data", 32'(bus.rsp_data), (((i - 2) % 2) == 0) ? 32'h2 : 32'h3);
            end else begin
                chk("cont_idle", 32'(bus.rsp_valid), 32'h0);
            end
            tick();
        end

        // Backpressure on a requester 1 stream; consumer stalls 5 cycles.
        n = 0;
        m = 0;
        for (int i = 0; i < 40 && m < 8; i++) begin
            bus.req_valid = (n < 8) ? 4'b0010 : 4'b0000;
            if (n < 8) bus.req_data[15:8] = bp_w[n];
            bus.rsp_ready = !(i >= 4 && i <= 8);
            #1;
            if (i >= 4 && i <= 8) begin
                chk("bp_ready_low", 32'(bus.req_ready), 32'h0);
                chk("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
                chk("bp_hold_data", 32'(bus.rsp_data), 32'(lut_model(bp_w[m])));
                chk("bp_hold_id", 32'(bus.rsp_id), 32'h1);
            end
            hs = bus.req_ready[1];
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("bp_data", 32'(bus.rsp_data), 32'(lut_model(bp_w[m])));
                chk("bp_id", 32'(bus.rsp_id), 32'h1);
                m++;
            end
            tick();
            if (hs) n++;
        end
        chk("bp_received", 32'(m), 32'h8);
        chk("bp_sent", 32'(n), 32'h8);
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_no_extra", 32'(bus.rsp_valid), 32'h0);
            tick();
        end

        // Fairness with gaps: move pointer to 1, then requesters 0 and 3.
        do_reset();
        bus.req_valid = 4'b0001;
        #1;
        chk("fair_setup", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b1001;
        #1;
        chk("fair_g3", 32'(bus.req_ready), 32'h8);
        tick();
        #1;
        chk("fair_g0", 32'(bus.req_ready), 32'h1);
        tick();
        #1;
        chk("fair_g3b", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fair_only3", 32'(bus.req_ready), 32'h8);
            tick();
        end
        drain(4);

        // Reset mid-stream with S1 and S2 full; pointer left at 2 beforehand.
        bus.req_data = {8'h00, 8'h01, 8'h20, 8'h00};
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'b0010;
            #1;
            chk("mid_fill_ready", 32'(bus.req_ready), 32'h2);
            tick();
        end
        chk("mid_full_valid", 32'(bus.rsp_valid), 32'h1);
        rst = 1'b1;
        bus.req_valid = 4'b0110;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_post_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_post_lut_in", 32'(bus.lut_in), 32'h0);
        chk("mid_post_g1", 32'(bus.req_ready), 32'h2);
        tick();
        #1;
        chk("mid_s1_only", 32'(bus.rsp_valid), 32'h0);
        chk("mid_then_g2", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        #1;
        chk("mid_first_valid", 32'(bus.rsp_valid), 32'h1);
        chk("mid_first_id", 32'(bus.rsp_id), 32'h1);
        chk("mid_first_data", 32'(bus.rsp_data), 32'h3);
        drain(4);

`ifdef NEURON_LUT_ARB_STATS_EN
        do_reset();
        #1;
        chk("stat_rst_grants", stat_grants, 32'h0);
        chk("stat_rst_stalls", stat_stalls, 32'h0);
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = (i < 10) ? 4'b0001 : 4'b0000;
            bus.rsp_ready = (i < 10);
            tick();
        end
        drain(4);
        chk("stat_grants", stat_grants, 32'd10);
        chk("stat_stalls", stat_stalls, 32'd3);
        do_reset();
        #1;
        chk("stat_clr_grants", stat_grants, 32'h0);
        chk("stat_clr_stalls", stat_stalls, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_lut_arbiter.md
Name: neuron_lut_arbiter

Overview:
- Shares one combinational neuron truth-table LUT (IN_W-bit input word, OUT_W-bit output) between NUM_REQ requesters.
- Round-robin arbitration with per-requester valid/ready handshakes.
- Two-stage registered pipeline into a single tagged response channel with backpressure.
- Sits between layer input staging logic and a time-multiplexed LUT neuron in resource-constrained builds.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- IN_W, 8, LUT input word width (fan-in × input bit-width)
- OUT_W, 2, LUT output width
- ID_W, 2, requester tag width; must satisfy 2**ID_W >= NUM_REQ

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*IN_W  packed request words; requester i at [i*IN_W +: IN_W]
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- lut_in  out  IN_W  registered word driven to shared LUT
- lut_out  in  OUT_W  combinational LUT result for lut_in
- rsp_valid  out  1  response valid
- rsp_data  out  OUT_W  LUT result
- rsp_id  out  ID_W  index of originating requester
- rsp_ready  in  1  response consumer ready

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, rsp_id=0, lut_in=0, stage-1 valid=0, RR pointer=0. req_ready is all-zero during the rst cycle.
- Stage S1 register: holds s1_valid, s1_data (drives lut_in), s1_id.
- Stage S2 register: holds rsp_valid, rsp_data, rsp_id.
- s2_adv = !rsp_valid || rsp_ready.
- s1_adv = !s1_valid || s2_adv.
- Arbitration (combinational):
  - Search req_valid starting at pointer P, wrapping modulo NUM_REQ.
  - The first set bit g is granted.
  - req_ready[g] = s1_adv && any(req_valid); all other bits 0.
  - Handshake on requester g means req_valid[g] && req_ready[g].
- On handshake: S1 loads req_data[g] and id g; P <= (g+1) mod NUM_REQ. P does not change without a handshake.
- If s1_adv and no request: s1_valid <= 0.
- If s2_adv: rsp_valid <= s1_valid. When s1_valid, rsp_data <= lut_out and rsp_id <= s1_id. Data and id hold when loading an empty bubble.
- Latency: handshake in cycle T gives rsp_valid in cycle T+2 with rsp_ready held high.
- Throughput: 1 response per cycle.
- Backpressure:
  - rsp_valid && !rsp_ready → S2 holds.
  - S1 holds if valid; req_ready goes all-zero.
  - No drops, no duplicates, responses in grant order.
- Single requester continuously valid: granted every cycle, since P wraps back to it.
- All requesters valid: grants rotate 0,1,..,NUM_REQ-1,0.
- req_data and req_valid may change while not granted; the value captured is the one present at the handshake.
- Reset mid-operation: in-flight S1/S2 contents are discarded; the first response after reset comes only from a post-reset handshake.
- lut_in changes only on S1 load. The LUT sees a stable word for one full cycle before S2 capture.

Optional Feature:
- Macro: NEURON_LUT_ARB_STATS_EN.
- Defined, adds outputs:
  - stat_grants (32 bits): increments on every request handshake.
  - stat_stalls (32 bits): increments each cycle rsp_valid && !rsp_ready.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent; function and timing are otherwise identical.

Decomposition:
- Package neuron_lut_arb_pkg holds:
  - the default widths (IN_W, OUT_W);
  - the function clog2 for ID_W checks;
  - the statistics counter width constant (32).
- One sub-module, rr_arbiter: parameter NUM_REQ; inputs req, pointer; outputs one-hot grant, grant index, any. Purely combinational.
- Pointer, pipeline registers and statistics stay in the top.

Test Plan:
- Bench LUT model: out = 2'b10 for in ∈ {8'h00, 8'h10, 8'h04, 8'h01}, else 2'b11.
- Single request: rsp_ready=1; requester 2 sends 8'h10 at cycle T → rsp_valid at T+2, rsp_data=2'b10, rsp_id=2; no other response.
- Full contention: all 4 valid for 8 cycles with data 8'h00/8'h40/8'h04/8'hFF (one word per requester) → ids 0,1,2,3,0,1,2,3 in consecutive cycles; data 10,11,10,11 repeating.
- Backpressure: stream from requester 1, rsp_ready low for 5 cycles mid-stream →
  - rsp_valid/rsp_data/rsp_id stable throughout the stall;
  - req_ready=0 after S1 fills;
  - no loss or duplication; sequence intact after release.
- Fairness with gaps: requesters 0 and 3 valid, P=1 → grant 3 first, then 0, then 3; requester 0 drops valid → 3 granted every cycle.
- Reset mid-stream: rst asserted for 1 cycle with S1 and S2 full →
  - next cycle rsp_valid=0, P=0;
  - requesters 1 and 2 then valid → requester 1 granted first.
- NEURON_LUT_ARB_STATS_EN build: 10 handshakes plus 3 stall cycles → stat_grants=10, stat_stalls=3; cleared to 0 by rst.
